// File: rtl/commit_flush_ctrl_pkg.sv
// Shared types for the commit flush controller: FSM states, abort kinds and target selection.
package commit_flush_ctrl_pkg;

    localparam int unsigned PcW = 64;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFlush = 2'd1,
        StDrain = 2'd2,
        StRedir = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        KindMispredict = 2'd0,
        KindTrap       = 2'd1,
        KindXRet       = 2'd2
    } abort_kind_e;

    // Trap outranks xRet, which outranks a plain mispredict.
    function automatic abort_kind_e abort_kind(input logic is_trap, input logic is_xret);
        if (is_trap) begin
            return KindTrap;
        end else if (is_xret) begin
            return KindXRet;
        end
        return KindMispredict;
    endfunction

    function automatic logic kind_writes_csr(input abort_kind_e kind);
        return (kind == KindTrap) || (kind == KindXRet);
    endfunction

endpackage

// File: rtl/commit_flush_ctrl_if.sv
// Abort/recovery handshake between commit, LSU, pc-generate and the flush controller.
interface commit_flush_ctrl_if;
    import commit_flush_ctrl_pkg::*;

    logic           commit_abort;
    logic           isTrap;
    logic           isXRet;
    logic [PcW-1:0] privileged_pc;
    logic [PcW-1:0] bru_target_pc;
    logic           lsu_busy;
    logic           redirect_ready;
    logic           commit_hold;
    logic           flush;
    logic           csr_except_we;
    logic           redirect_valid;
    logic [PcW-1:0] redirect_pc;
    logic           drain_timeout;

    modport master (
        output commit_abort, isTrap, isXRet, privileged_pc, bru_target_pc, lsu_busy,
               redirect_ready,
        input  commit_hold, flush, csr_except_we, redirect_valid, redirect_pc, drain_timeout
    );

    modport slave (
        input  commit_abort, isTrap, isXRet, privileged_pc, bru_target_pc, lsu_busy,
               redirect_ready,
        output commit_hold, flush, csr_except_we, redirect_valid, redirect_pc, drain_timeout
    );

endinterface

// File: rtl/commit_flush_ctrl_flush_wdt.sv
// Drain watchdog: counts DRAIN cycles and forces an exit when the LSU never goes idle.
module commit_flush_ctrl_flush_wdt #(
    parameter int unsigned DRAIN_TIMEOUT = 1024,
    parameter int unsigned CNT_W         = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_busy,
    output logic o_expire,
    output logic o_flag
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DRAIN_TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_flag;
    logic             w_expire;

    assign w_expire = i_en && i_busy && (r_cnt == LastCnt);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else begin
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_en) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_expire) begin
                r_flag <= 1'b1;
            end
        end
    end

    assign o_expire = w_expire;
    assign o_flag   = r_flag;

endmodule

// File: rtl/commit_flush_ctrl.sv
// Commit-abort recovery sequencer: flush, drain the LSU, then redirect pc-generate.
// Optional drain watchdog enabled by defining FLUSH_WDT_EN.
module commit_flush_ctrl
    import commit_flush_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_TIMEOUT = 1024,
    parameter int unsigned CNT_W         = 10
) (
    input logic               CLK,
    input logic               RSTn,
    commit_flush_ctrl_if.slave bus
);

    if ((64'd1 << CNT_W) < 64'(DRAIN_TIMEOUT)) begin : g_cnt_w_check
        $error("CNT_W too narrow for DRAIN_TIMEOUT");
    end

    state_e         r_state;
    state_e         w_state_d;
    abort_kind_e    r_kind;
    logic [PcW-1:0] r_pc;
    abort_kind_e    w_kind;
    logic [PcW-1:0] w_target;
    logic           w_flush;
    logic           w_csr_we;
    logic           w_redir_valid;
    logic           w_wdt_expire;
    logic           w_wdt_flag;

    assign w_kind   = abort_kind(bus.isTrap, bus.isXRet);
    assign w_target = (w_kind == KindMispredict) ? bus.bru_target_pc : bus.privileged_pc;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= StIdle;
            r_kind  <= KindMispredict;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StIdle && bus.commit_abort) begin
                r_kind <= w_kind;
                r_pc   <= w_target;
            end
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_flush       = 1'b0;
        w_csr_we      = 1'b0;
        w_redir_valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.commit_abort) w_state_d = StFlush;
            end
            StFlush: begin
                w_flush   = 1'b1;
                w_csr_we  = kind_writes_csr(r_kind);
                w_state_d = StDrain;
            end
            StDrain: begin
                // Committed stores survive the flush and must retire before fetch restarts.
                if (!bus.lsu_busy || w_wdt_expire) w_state_d = StRedir;
            end
            StRedir: begin
                w_redir_valid = 1'b1;
                if (bus.redirect_ready) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

`ifdef FLUSH_WDT_EN
    commit_flush_ctrl_flush_wdt #(
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
        .CNT_W         (CNT_W)
    ) u_flush_wdt (
        .i_clk    (CLK),
        .i_rst_n  (RSTn),
        .i_clr    (r_state == StFlush),
        .i_en     (r_state == StDrain),
        .i_busy   (bus.lsu_busy),
        .o_expire (w_wdt_expire),
        .o_flag   (w_wdt_flag)
    );
`else
    assign w_wdt_expire = 1'b0;
    assign w_wdt_flag   = 1'b0;
`endif

    assign bus.commit_hold    = (r_state != StIdle);
    assign bus.flush          = w_flush;
    assign bus.csr_except_we  = w_csr_we;
    assign bus.redirect_valid = w_redir_valid;
    assign bus.redirect_pc    = r_pc;
    assign bus.drain_timeout  = w_wdt_flag;

endmodule

// File: tb/tb_commit_flush_ctrl.sv
// Self-checking bench for commit_flush_ctrl: vector table plus scoreboard, and corner sequences.
module tb_commit_flush_ctrl;
    import commit_flush_ctrl_pkg::*;

    localparam int unsigned TbTimeout = 16;
    localparam int unsigned TbCntW    = 5;

    typedef struct {
        logic        trap;
        logic        xret;
        logic [63:0] ppc;
        logic [63:0] bpc;
        int          busy;
        int          rdy;
        logic        exp_csr;
        logic [63:0] exp_pc;
    } vec_t;

    typedef struct {
        logic        csr;
        logic [63:0] pc;
    } sb_t;

    logic CLK = 1'b0;
    logic RSTn;
    int   n_checks = 0;
    int   n_errors = 0;
    int   flush_cnt = 0;
    int   csr_cnt = 0;
    sb_t  exp_q[$];
    vec_t vecs[5];

    commit_flush_ctrl_if bus ();

    commit_flush_ctrl #(
        .DRAIN_TIMEOUT (TbTimeout),
        .CNT_W         (TbCntW)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (bus.flush) flush_cnt++;
        if (bus.csr_except_we) csr_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.commit_abort  = 1'b0;
        bus.isTrap        = 1'b0;
        bus.isXRet        = 1'b0;
        bus.privileged_pc = 64'h0;
        bus.bru_target_pc = 64'h0;
    endtask

    task automatic run_vec(input vec_t v);
        sb_t e;
        @(negedge CLK);
        bus.commit_abort   = 1'b1;
        bus.isTrap         = v.trap;
        bus.isXRet         = v.xret;
        bus.privileged_pc  = v.ppc;
        bus.bru_target_pc  = v.bpc;
        bus.lsu_busy       = (v.busy > 0);
        bus.redirect_ready = (v.rdy == 0);
        exp_q.push_back('{csr: v.exp_csr, pc: v.exp_pc});
        @(negedge CLK);
        idle_inputs();
        chk("flush_pulse", {63'd0, bus.flush}, 64'd1);
        chk("hold_in_flush", {63'd0, bus.commit_hold}, 64'd1);
        chk("csr_we", {63'd0, bus.csr_except_we}, {63'd0, exp_q[0].csr});
        @(negedge CLK);
        chk("flush_one_shot", {63'd0, bus.flush}, 64'd0);
        chk("csr_one_shot", {63'd0, bus.csr_except_we}, 64'd0);
        chk("no_early_valid", {63'd0, bus.redirect_valid}, 64'd0);
        repeat (v.busy) begin
            @(negedge CLK);
            chk("valid_while_busy", {63'd0, bus.redirect_valid}, 64'd0);
        end
        bus.lsu_busy = 1'b0;
        @(negedge CLK);
        chk("redirect_valid", {63'd0, bus.redirect_valid}, 64'd1);
        e = exp_q.pop_front();
        chk("redirect_pc", bus.redirect_pc, e.pc);
        for (int i = 0; i < v.rdy; i++) begin
            @(negedge CLK);
            chk("valid_held", {63'd0, bus.redirect_valid}, 64'd1);
            chk("pc_stable", bus.redirect_pc, e.pc);
        end
        bus.redirect_ready = 1'b1;
        @(negedge CLK);
        chk("idle_hold", {63'd0, bus.commit_hold}, 64'd0);
        chk("idle_valid", {63'd0, bus.redirect_valid}, 64'd0);
    endtask

    initial begin
        int  fc0;
        int  cc0;
        int  n;
        logic got;

        vecs[0] = '{1'b0, 1'b0, 64'hDEAD_0000_0000_0001, 64'h8000_0100, 0, 0, 1'b0, 64'h8000_0100};
        vecs[1] = '{1'b1, 1'b0, 64'h8000_0004, 64'hDEAD_0000_0000_0002, 5, 0, 1'b1, 64'h8000_0004};
        vecs[2] = '{1'b0, 1'b1, 64'h8000_2000, 64'hDEAD_0000_0000_0003, 0, 3, 1'b1, 64'h8000_2000};
        vecs[3] = '{1'b1, 1'b1, 64'h8000_0008, 64'hDEAD_0000_0000_0004, 2, 1, 1'b1, 64'h8000_0008};
        vecs[4] = '{1'b0, 1'b0, 64'hDEAD_0000_0000_0005, 64'h1234_5678_9ABC_DEF0, 1, 2, 1'b0,
                    64'h1234_5678_9ABC_DEF0};

        RSTn = 1'b0;
        idle_inputs();
        bus.lsu_busy       = 1'b0;
        bus.redirect_ready = 1'b1;
        #12;
        chk("rst_hold", {63'd0, bus.commit_hold}, 64'd0);
        chk("rst_flush", {63'd0, bus.flush}, 64'd0);
        chk("rst_csr", {63'd0, bus.csr_except_we}, 64'd0);
        chk("rst_valid", {63'd0, bus.redirect_valid}, 64'd0);
        chk("rst_pc", bus.redirect_pc, 64'd0);
        chk("rst_dt", {63'd0, bus.drain_timeout}, 64'd0);
        @(negedge CLK);
        RSTn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Second abort while recovery is in progress must not start another flush.
        #1;
        fc0 = flush_cnt;
        cc0 = csr_cnt;
        @(negedge CLK);
        bus.commit_abort  = 1'b1;
        bus.bru_target_pc = 64'h8000_0300;
        bus.lsu_busy      = 1'b1;
        @(negedge CLK);
        bus.isTrap        = 1'b1;
        bus.privileged_pc = 64'hDEAD_BEEF_0000_0000;
        repeat (4) @(negedge CLK);
        bus.lsu_busy = 1'b0;
        idle_inputs();
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK);
            got = bus.redirect_valid;
        end
        chk("hold_abort_redirect", {63'd0, got}, 64'd1);
        chk("hold_abort_pc", bus.redirect_pc, 64'h8000_0300);
        @(negedge CLK);
        #1;
        chk("hold_abort_idle", {63'd0, bus.commit_hold}, 64'd0);
        chk("single_flush", 64'(flush_cnt - fc0), 64'd1);
        chk("no_csr_write", 64'(csr_cnt - cc0), 64'd0);

        // LSU never drains.
        @(negedge CLK);
        bus.commit_abort   = 1'b1;
        bus.bru_target_pc  = 64'h8000_0500;
        bus.lsu_busy       = 1'b1;
        bus.redirect_ready = 1'b1;
        @(negedge CLK);
        idle_inputs();
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            if (bus.redirect_valid) got = 1'b1;
            else n++;
        end
`ifdef FLUSH_WDT_EN
        chk("wdt_fired", {63'd0, got}, 64'd1);
        chk("wdt_drain_cycles", 64'(n), 64'(TbTimeout));
        chk("wdt_flag_set", {63'd0, bus.drain_timeout}, 64'd1);
        chk("wdt_pc", bus.redirect_pc, 64'h8000_0500);
        @(negedge CLK);
        chk("wdt_idle", {63'd0, bus.commit_hold}, 64'd0);
        chk("wdt_flag_sticky", {63'd0, bus.drain_timeout}, 64'd1);
        bus.lsu_busy = 1'b0;
`else
        chk("no_wdt_exit", {63'd0, got}, 64'd0);
        chk("dt_tied_low", {63'd0, bus.drain_timeout}, 64'd0);
        bus.lsu_busy = 1'b0;
        @(negedge CLK);
        chk("late_drain_valid", {63'd0, bus.redirect_valid}, 64'd1);
        @(negedge CLK);
        chk("late_drain_idle", {63'd0, bus.commit_hold}, 64'd0);
`endif

        // Reset while offering the redirect.
        @(negedge CLK);
        bus.commit_abort   = 1'b1;
        bus.bru_target_pc  = 64'h8000_0400;
        bus.redirect_ready = 1'b0;
        @(negedge CLK);
        idle_inputs();
        repeat (2) @(negedge CLK);
        chk("pre_rst_valid", {63'd0, bus.redirect_valid}, 64'd1);
        #2;
        RSTn = 1'b0;
        #1;
        chk("async_hold", {63'd0, bus.commit_hold}, 64'd0);
        chk("async_valid", {63'd0, bus.redirect_valid}, 64'd0);
        chk("async_pc", bus.redirect_pc, 64'd0);
        chk("async_flush", {63'd0, bus.flush}, 64'd0);
        chk("async_dt", {63'd0, bus.drain_timeout}, 64'd0);
        @(negedge CLK);
        RSTn               = 1'b1;
        bus.redirect_ready = 1'b1;
        @(negedge CLK);
        chk("post_rst_valid", {63'd0, bus.redirect_valid}, 64'd0);
        chk("post_rst_hold", {63'd0, bus.commit_hold}, 64'd0);
        run_vec(vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
